sincos_gen: RTL and testbench

// Parametrised, pipelined sin/cos generator for the NCO path: maps a phase word to

---
 rtl/sincos_gen.sv | 208 ++++++++++++++++++++
 tb/tb_sincos_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sincos_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | sincos_gen : pipelined quarter-wave ROM sin/cos generator with           |
// |              first-order correction, conjugate mode and saturation.      |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+

module sincos_gen #(
  parameter int COARSE_W = 8,
  parameter int FINE_W   = 10,
  parameter int OUT_W    = 19,
  parameter int TWO_PI_Q = 205887,
  localparam int PHASE_W = 2 + COARSE_W + FINE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [PHASE_W-1:0] in_phase,
  input  logic               in_conj,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_sin,
  output logic [OUT_W-1:0]   out_cos
);

  localparam int MAG_W     = OUT_W - 1;
  localparam int M_W       = FINE_W - 1;
  localparam int ROM_DEPTH = 2 ** COARSE_W;
  localparam int LAT       = 7;
  localparam int SHIFT     = PHASE_W + 16;
  localparam int P4_W      = MAG_W + FINE_W;
  localparam int PROD_W    = P4_W + 32;
  localparam int SUM_W     = MAG_W + 2;
  localparam logic [MAG_W-1:0] A_MAG = {MAG_W{1'b1}};
  localparam longint PI_Q30   = 64'sd3373259426;
  localparam longint ONE_Q30  = 64'sd1073741824;
  localparam longint HALF_Q30 = 64'sd536870912;

  typedef struct packed {
    logic plus;
    logic sin_neg;
    logic cos_neg;
  } side_t;

  // ROM contents are evaluated at elaboration with a Q30 Taylor series,
  // entry k sampling the midpoint of coarse cell k.
  function automatic logic [2*MAG_W-1:0] rom_entry(input int k);
    longint x;
    longint x2;
    longint term;
    longint s_acc;
    longint c_acc;
    longint s_scaled;
    longint c_scaled;
    x     = (PI_Q30 * longint'(2 * k + 1)) >>> (COARSE_W + 2);
    x2    = (x * x) >>> 30;
    term  = x;
    s_acc = x;
    for (int n = 1; n <= 8; n++) begin
      term  = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      s_acc = s_acc + term;
    end
    term  = ONE_Q30;
    c_acc = ONE_Q30;
    for (int n = 1; n <= 8; n++) begin
      term  = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
      c_acc = c_acc + term;
    end
    s_scaled = (s_acc * longint'(A_MAG) + HALF_Q30) >>> 30;
    c_scaled = (c_acc * longint'(A_MAG) + HALF_Q30) >>> 30;
    return {MAG_W'(s_scaled), MAG_W'(c_scaled)};
  endfunction

  function automatic logic [MAG_W-1:0] clamp_mag(input logic [SUM_W-1:0] v);
    if (v[SUM_W-1]) begin
      return '0;
    end else if (v > SUM_W'(A_MAG)) begin
      return A_MAG;
    end else begin
      return v[MAG_W-1:0];
    end
  endfunction

  logic [2*MAG_W-1:0] rom_table [ROM_DEPTH];

  for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
    localparam logic [2*MAG_W-1:0] ENTRY = rom_entry(k);
    assign rom_table[k] = ENTRY;
  end

  logic [LAT-1:0]     valid_d, valid_q;
  logic [PHASE_W-1:0] phase1_d, phase1_q;
  logic               conj1_d, conj1_q;
  logic [COARSE_W-1:0] addr2_d, addr2_q;
  logic [M_W-1:0]     m2_d, m2_q, m3_d, m3_q;
  side_t              side2_d, side2_q, side3_d, side3_q, side4_d, side4_q;
  side_t              side5_d, side5_q, side6_d, side6_q;
  logic [MAG_W-1:0]   smag3_d, smag3_q, cmag3_d, cmag3_q;
  logic [MAG_W-1:0]   smag4_d, smag4_q, cmag4_d, cmag4_q;
  logic [P4_W-1:0]    sp4_d, sp4_q, cp4_d, cp4_q;
  logic [MAG_W-1:0]   smag5_d, smag5_q, cmag5_d, cmag5_q;
  logic [MAG_W-1:0]   scorr5_d, scorr5_q, ccorr5_d, ccorr5_q;
  logic [MAG_W-1:0]   smag6_d, smag6_q, cmag6_d, cmag6_q;
  logic [OUT_W-1:0]   out_sin_d, out_sin_q, out_cos_d, out_cos_q;

  logic [1:0]          quad2;
  logic [COARSE_W-1:0] coarse2;
  logic [FINE_W-1:0]   fine2;
  logic                fine_neg;
  logic [2*MAG_W-1:0]  rom_word;
  logic [SUM_W-1:0]    sin_sum, cos_sum;

  always_comb begin
    valid_d  = {valid_q[LAT-2:0], in_valid};

    phase1_d = in_phase;
    conj1_d  = in_conj;

    quad2    = phase1_q[PHASE_W-1 -: 2];
    coarse2  = phase1_q[FINE_W +: COARSE_W];
    fine2    = phase1_q[FINE_W-1:0];
    fine_neg = ~fine2[FINE_W-1];
    addr2_d  = quad2[0] ? ~coarse2 : coarse2;
    m2_d     = fine2[FINE_W-1] ? fine2[M_W-1:0] : ~fine2[M_W-1:0];
    // Odd quadrants read the ROM mirrored, which flips the slope direction.
    side2_d.plus    = ~(fine_neg ^ quad2[0]);
    side2_d.sin_neg = quad2[1] ^ conj1_q;
    side2_d.cos_neg = quad2[1] ^ quad2[0];

    rom_word = rom_table[addr2_q];
    smag3_d  = rom_word[2*MAG_W-1 -: MAG_W];
    cmag3_d  = rom_word[MAG_W-1:0];
    m3_d     = m2_q;
    side3_d  = side2_q;

    sp4_d    = P4_W'(smag3_q) * P4_W'({m3_q, 1'b1});
    cp4_d    = P4_W'(cmag3_q) * P4_W'({m3_q, 1'b1});
    smag4_d  = smag3_q;
    cmag4_d  = cmag3_q;
    side4_d  = side3_q;

    scorr5_d = MAG_W'((PROD_W'(sp4_q) * PROD_W'(TWO_PI_Q)) >> SHIFT);
    ccorr5_d = MAG_W'((PROD_W'(cp4_q) * PROD_W'(TWO_PI_Q)) >> SHIFT);
    smag5_d  = smag4_q;
    cmag5_d  = cmag4_q;
    side5_d  = side4_q;

    sin_sum  = side5_q.plus ? ({2'b00, smag5_q} + {2'b00, ccorr5_q})
                            : ({2'b00, smag5_q} - {2'b00, ccorr5_q});
    cos_sum  = side5_q.plus ? ({2'b00, cmag5_q} - {2'b00, scorr5_q})
                            : ({2'b00, cmag5_q} + {2'b00, scorr5_q});
    smag6_d  = clamp_mag(sin_sum);
    cmag6_d  = clamp_mag(cos_sum);
    side6_d  = side5_q;

    out_sin_d = out_sin_q;
    out_cos_d = out_cos_q;
    if (valid_q[LAT-2]) begin
      out_sin_d = side6_q.sin_neg ? -{1'b0, smag6_q} : {1'b0, smag6_q};
      out_cos_d = side6_q.cos_neg ? -{1'b0, cmag6_q} : {1'b0, cmag6_q};
    end
  end

  // Datapath stages carry no reset; only valid and the output registers clear.
  always_ff @(posedge clk) begin
    phase1_q <= phase1_d;
    conj1_q  <= conj1_d;
    addr2_q  <= addr2_d;
    m2_q     <= m2_d;
    side2_q  <= side2_d;
    smag3_q  <= smag3_d;
    cmag3_q  <= cmag3_d;
    m3_q     <= m3_d;
    side3_q  <= side3_d;
    sp4_q    <= sp4_d;
    cp4_q    <= cp4_d;
    smag4_q  <= smag4_d;
    cmag4_q  <= cmag4_d;
    side4_q  <= side4_d;
    scorr5_q <= scorr5_d;
    ccorr5_q <= ccorr5_d;
    smag5_q  <= smag5_d;
    cmag5_q  <= cmag5_d;
    side5_q  <= side5_d;
    smag6_q  <= smag6_d;
    cmag6_q  <= cmag6_d;
    side6_q  <= side6_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      out_sin_q <= '0;
      out_cos_q <= '0;
    end else begin
      valid_q   <= valid_d;
      out_sin_q <= out_sin_d;
      out_cos_q <= out_cos_d;
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_sin   = out_sin_q;
  assign out_cos   = out_cos_q;

endmodule

`default_nettype wire

// File: tb/tb_sincos_gen.sv
`timescale 1ns/1ps
`default_nettype none
// tb_sincos_gen : directed self-checking bench for sincos_gen.

module tb_sincos_gen;

  localparam int  PHASE_W = 20;
  localparam int  OUT_W   = 19;
  localparam int  A       = 262143;
  localparam int  TOL     = 4;
  localparam real PI      = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [PHASE_W-1:0] in_phase;
  logic               in_conj;
  logic               out_valid;
  logic [OUT_W-1:0]   out_sin;
  logic [OUT_W-1:0]   out_cos;

  int n_checks = 0;
  int n_pass   = 0;

  logic [PHASE_W-1:0] stim_phase [$];
  logic               stim_conj  [$];

  always #5 clk = ~clk;

  sincos_gen dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_phase (in_phase),
    .in_conj  (in_conj),
    .out_valid(out_valid),
    .out_sin  (out_sin),
    .out_cos  (out_cos)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [PHASE_W-1:0] p, input logic cj);
    in_valid = v;
    in_phase = p;
    in_conj  = cj;
  endtask

  function automatic int round_near(input real x);
    return $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    repeat (3) tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (out_sin !== '0) $display("FAIL reset_sin: got %0d want 0", $signed(out_sin));
    else n_pass++;
    n_checks++;
    if (out_cos !== '0) $display("FAIL reset_cos: got %0d want 0", $signed(out_cos));
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cardinal();
    logic [PHASE_W-1:0] ph [6] = '{20'h00000, 20'h40000, 20'h80000, 20'hC0000, 20'h20000, 20'h20000};
    logic               cj [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int                 es [6] = '{0, A, 0, -A, -185364, 185364};
    int                 ec [6] = '{A, 0, -A, 0, 185364, 185364};
    int s;
    int c;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ph[i], cj[i]);
      tick();
      drive(1'b0, '0, 1'b0);
      repeat (5) tick();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL card%0d_early: out_valid %b want 0", i, out_valid);
      else n_pass++;
      tick();
      s = int'($signed(out_sin));
      c = int'($signed(out_cos));
      n_checks++;
      if (out_valid !== 1'b1) $display("FAIL card%0d_valid: out_valid %b want 1", i, out_valid);
      else n_pass++;
      n_checks++;
      if (s - es[i] > TOL || es[i] - s > TOL)
        $display("FAIL card%0d_sin: got %0d want %0d+/-%0d", i, s, es[i], TOL);
      else n_pass++;
      n_checks++;
      if (c - ec[i] > TOL || ec[i] - c > TOL)
        $display("FAIL card%0d_cos: got %0d want %0d+/-%0d", i, c, ec[i], TOL);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL card%0d_pulse: out_valid %b want 0", i, out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back(input string tag);
    int  n;
    int  j;
    int  s;
    int  c;
    int  es;
    int  ec;
    real th;
    n = stim_phase.size();
    for (int i = 0; i < n + 6; i++) begin
      if (i < n) drive(1'b1, stim_phase[i], stim_conj[i]);
      else       drive(1'b0, '0, 1'b0);
      tick();
      if (i >= 6) begin
        j  = i - 6;
        th = 2.0 * PI * real'(stim_phase[j]) / (2.0 ** PHASE_W);
        es = round_near(real'(A) * $sin(th));
        ec = round_near(real'(A) * $cos(th));
        if (stim_conj[j]) es = -es;
        s  = int'($signed(out_sin));
        c  = int'($signed(out_cos));
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL %s_valid[%0d]: out_valid %b want 1", tag, j, out_valid);
        else n_pass++;
        n_checks++;
        if (s - es > TOL || es - s > TOL || c - ec > TOL || ec - c > TOL ||
            s > A || s < -A || c > A || c < -A)
          $display("FAIL %s_value[%0d]: phase %h got (%0d,%0d) want (%0d,%0d)+/-%0d",
                   tag, j, stim_phase[j], s, c, es, ec, TOL);
        else n_pass++;
      end
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL %s_drain: out_valid %b want 0", tag, out_valid);
    else n_pass++;
  endtask

  task automatic test_valid_pattern();
    logic               pat   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [PHASE_W-1:0] phs   [5] = '{20'h40000, 20'h12345, 20'h80000, 20'hC0000, 20'h0ABCD};
    logic               exp_v [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int                 exp_s [6] = '{A, A, 0, -A, -A, -A};
    int                 exp_c [6] = '{0, 0, -A, 0, 0, 0};
    int j;
    int s;
    int c;
    for (int i = 0; i < 12; i++) begin
      if (i < 5) drive(pat[i], phs[i], 1'b0);
      else       drive(1'b0, '0, 1'b0);
      tick();
      if (i < 6) begin
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL pat_lead[%0d]: out_valid %b want 0", i, out_valid);
        else n_pass++;
      end else begin
        j = i - 6;
        s = int'($signed(out_sin));
        c = int'($signed(out_cos));
        n_checks++;
        if (out_valid !== exp_v[j]) $display("FAIL pat_valid[%0d]: out_valid %b want %b", j, out_valid, exp_v[j]);
        else n_pass++;
        n_checks++;
        if (s - exp_s[j] > TOL || exp_s[j] - s > TOL || c - exp_c[j] > TOL || exp_c[j] - c > TOL)
          $display("FAIL pat_value[%0d]: got (%0d,%0d) want (%0d,%0d)+/-%0d", j, s, c, exp_s[j], exp_c[j], TOL);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    int s;
    int c;
    rst = 1'b0;
    drive(1'b1, 20'h20000, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    drive(1'b1, 20'h80000, 1'b0);
    for (int t = 0; t < 2; t++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_sin !== '0 || out_cos !== '0)
        $display("FAIL mid_rst[%0d]: got valid %b sin %0d cos %0d want 0 0 0",
                 t, out_valid, $signed(out_sin), $signed(out_cos));
      else n_pass++;
    end
    rst = 1'b0;
    drive(1'b1, 20'h40000, 1'b0);
    for (int t = 1; t <= 6; t++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_sin !== '0 || out_cos !== '0)
        $display("FAIL mid_post[%0d]: got valid %b sin %0d cos %0d want 0 0 0",
                 t, out_valid, $signed(out_sin), $signed(out_cos));
      else n_pass++;
    end
    tick();
    s = int'($signed(out_sin));
    c = int'($signed(out_cos));
    n_checks++;
    if (out_valid !== 1'b1 || s - A > TOL || A - s > TOL || c > TOL || c < -TOL)
      $display("FAIL mid_first: got valid %b (%0d,%0d) want 1 (%0d,0)+/-%0d", out_valid, s, c, A, TOL);
    else n_pass++;
    drive(1'b0, '0, 1'b0);
    repeat (8) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    test_reset();
    test_cardinal();

    stim_phase.delete();
    stim_conj.delete();
    for (int k = 0; k < 64; k++) begin
      stim_phase.push_back(PHASE_W'(32'hFFFE0 + k));
      stim_conj.push_back(1'b0);
    end
    test_back_to_back("sweep");

    stim_phase.delete();
    stim_conj.delete();
    for (int k = 0; k < 160; k++) begin
      stim_phase.push_back(PHASE_W'($urandom));
      stim_conj.push_back(1'($urandom_range(0, 1)));
    end
    test_back_to_back("rand");

    test_valid_pattern();
    test_reset_midstream();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
